// File: rtl/pixel_demux.sv
// pixel_demux: steers one pixel stream into NUM_OUT independently
// back-pressured output lanes. The target lane is either the explicit select
// or an internal round-robin pointer that returns to lane 0 at end of row.
module pixel_demux #(
  parameter int NUM_OUT   = 4,
  parameter int BUS_WIDTH = 8,
  parameter int SEL_WIDTH = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           mode,
  input  logic [SEL_WIDTH-1:0]           select,
  input  logic [BUS_WIDTH-1:0]           in_data,
  input  logic                           in_valid,
  input  logic                           in_last,
  output logic                           in_ready,
  output logic [NUM_OUT*BUS_WIDTH-1:0]   out_data,
  output logic [NUM_OUT-1:0]             out_valid,
  input  logic [NUM_OUT-1:0]             out_ready,
  output logic [SEL_WIDTH-1:0]           rr_ptr
);

  // Every encodable pointer value gets a slot so that indexing by tgt is
  // always in bounds; slots past NUM_OUT never report free.
  localparam int PAD = 1 << SEL_WIDTH;
  localparam logic [SEL_WIDTH-1:0] LAST_LANE = SEL_WIDTH'(NUM_OUT - 1);

  logic [SEL_WIDTH-1:0] tgt;
  logic                 in_range;
  logic                 accept;
  logic [PAD-1:0]       lane_free;
  logic [NUM_OUT-1:0]   load;

  assign tgt      = mode ? rr_ptr : select;
  assign in_range = ({1'b0, tgt} < (SEL_WIDTH + 1)'(NUM_OUT));
  // Never looks at in_valid, so the upstream can wait on in_ready safely.
  assign in_ready = in_range && lane_free[tgt];
  assign accept   = in_valid && in_ready;

  genvar gi;
  generate
    for (gi = 0; gi < PAD; gi++) begin : g_lane
      if (gi < NUM_OUT) begin : g_real
        logic                 valid_reg;
        logic [BUS_WIDTH-1:0] data_reg;

        // A lane can take a new pixel when empty or when it drains this edge.
        assign lane_free[gi] = !valid_reg || out_ready[gi];
        assign load[gi]      = accept && (tgt == SEL_WIDTH'(gi));

        // One-entry lane register: load wins over drain, stalled data is held.
        always_ff @(posedge clk or posedge reset) begin
          if (reset) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
          end else if (load[gi]) begin
            valid_reg <= 1'b1;
            data_reg  <= in_data;
          end else if (valid_reg && out_ready[gi]) begin
            valid_reg <= 1'b0;
          end
        end

        assign out_valid[gi]                           = valid_reg;
        assign out_data[gi*BUS_WIDTH +: BUS_WIDTH]     = data_reg;
      end else begin : g_pad
        assign lane_free[gi] = 1'b0;
      end
    end
  endgenerate

  // Round-robin pointer advances only on accepted pixels in round-robin mode;
  // end of row forces lane 0 so every row starts on the same lane.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (accept && mode) begin
      if (in_last) begin
        rr_ptr <= '0;
      end else if (rr_ptr == LAST_LANE) begin
        rr_ptr <= '0;
      end else begin
        rr_ptr <= rr_ptr + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pixel_demux.sv
// Directed testbench for pixel_demux: a 4-lane instance for the main
// scenarios and a 3-lane instance for the out-of-range target case.
module tb_pixel_demux;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  // 4-lane instance
  logic        mode = 1'b0;
  logic [1:0]  select = 2'd0;
  logic [7:0]  in_data = 8'd0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic [31:0] out_data;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready = 4'b0000;
  logic [1:0]  rr_ptr;

  // 3-lane instance
  logic        mode3 = 1'b0;
  logic [1:0]  select3 = 2'd0;
  logic [7:0]  in_data3 = 8'd0;
  logic        in_valid3 = 1'b0;
  logic        in_last3 = 1'b0;
  logic        in_ready3;
  logic [23:0] out_data3;
  logic [2:0]  out_valid3;
  logic [2:0]  out_ready3 = 3'b000;
  logic [1:0]  rr_ptr3;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pixel_demux #(.NUM_OUT(4), .BUS_WIDTH(8), .SEL_WIDTH(2)) dut (
    .clk(clk), .reset(reset), .mode(mode), .select(select),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .rr_ptr(rr_ptr)
  );

  pixel_demux #(.NUM_OUT(3), .BUS_WIDTH(8), .SEL_WIDTH(2)) dut3 (
    .clk(clk), .reset(reset), .mode(mode3), .select(select3),
    .in_data(in_data3), .in_valid(in_valid3), .in_last(in_last3),
    .in_ready(in_ready3), .out_data(out_data3), .out_valid(out_valid3),
    .out_ready(out_ready3), .rr_ptr(rr_ptr3)
  );

  function automatic logic [7:0] lane(input int k);
    return out_data[k*8 +: 8];
  endfunction

  // Drive the 4-lane inputs on the falling edge.
  task automatic drive(input logic m, input logic [1:0] s, input logic [7:0] d,
                       input logic v, input logic l);
    @(negedge clk);
    mode = m; select = s; in_data = d; in_valid = v; in_last = l;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_valid3 = 1'b0; in_last3 = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    tests++;
    if (out_valid !== 4'b0000 || out_data !== 32'h0 || rr_ptr !== 2'd0) begin
      fails++;
      $display("FAIL reset_init: valid=%b data=%h rr=%0d, want 0000/0/0", out_valid, out_data, rr_ptr);
    end
    @(negedge clk); reset = 1'b0;
    out_ready = 4'b0000;
    // lane 0 via round-robin, then 0xA5 addressed to lane 2
    drive(1'b1, 2'd0, 8'h01, 1'b1, 1'b0);
    drive(1'b0, 2'd2, 8'hA5, 1'b1, 1'b0);
    drive(1'b0, 2'd2, 8'h00, 1'b0, 1'b0);
    #1;
    tests++;
    if (out_valid !== 4'b0101 || lane(2) !== 8'hA5 || rr_ptr !== 2'd1) begin
      fails++;
      $display("FAIL reset_prefill: valid=%b lane2=%h rr=%0d, want 0101/a5/1", out_valid, lane(2), rr_ptr);
    end
    // asynchronous assertion away from any clock edge
    reset = 1'b1;
    #1;
    tests++;
    if (out_valid !== 4'b0000 || out_data !== 32'h0 || rr_ptr !== 2'd0) begin
      fails++;
      $display("FAIL reset_async: valid=%b data=%h rr=%0d, want 0000/0/0", out_valid, out_data, rr_ptr);
    end
    $display("[TB] reset: async clear checked");
    @(negedge clk); reset = 1'b0;
    drive(1'b1, 2'd3, 8'h5A, 1'b1, 1'b0);
    @(posedge clk); #1;
    tests++;
    if (out_valid !== 4'b0001 || lane(0) !== 8'h5A) begin
      fails++;
      $display("FAIL reset_first_accept: valid=%b lane0=%h, want 0001/5a", out_valid, lane(0));
    end
    in_valid = 1'b0;
  endtask

  task automatic test_round_robin();
    int k;
    do_reset();
    out_ready = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      k = i % 4;
      drive(1'b1, 2'd0, 8'h10 + 8'(i), 1'b1, 1'b0);
      #1;
      tests++;
      if (in_ready !== 1'b1 || rr_ptr !== 2'(k)) begin
        fails++;
        $display("FAIL rr_ready_%0d: in_ready=%b rr=%0d, want 1/%0d", i, in_ready, rr_ptr, k);
      end
      @(posedge clk); #1;
      tests++;
      if (out_valid !== 4'(1 << k) || lane(k) !== 8'h10 + 8'(i)) begin
        fails++;
        $display("FAIL rr_lane_%0d: valid=%b lane%0d=%h, want %b/%h", i, out_valid, k, lane(k), 4'(1 << k), 8'h10 + 8'(i));
      end
      $display("[TB] rr pixel %h -> lane %0d", 8'h10 + 8'(i), k);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_row_reset();
    do_reset();
    out_ready = 4'b1111;
    drive(1'b1, 2'd0, 8'h20, 1'b1, 1'b0);
    drive(1'b1, 2'd0, 8'h21, 1'b1, 1'b0);
    drive(1'b1, 2'd0, 8'h22, 1'b1, 1'b1);
    @(posedge clk); #1;
    tests++;
    if (rr_ptr !== 2'd0 || out_valid !== 4'b0100 || lane(2) !== 8'h22) begin
      fails++;
      $display("FAIL row_last: rr=%0d valid=%b lane2=%h, want 0/0100/22", rr_ptr, out_valid, lane(2));
    end
    drive(1'b1, 2'd0, 8'h23, 1'b1, 1'b0);
    @(posedge clk); #1;
    tests++;
    if (out_valid !== 4'b0001 || lane(0) !== 8'h23 || rr_ptr !== 2'd1) begin
      fails++;
      $display("FAIL row_next: valid=%b lane0=%h rr=%0d, want 0001/23/1", out_valid, lane(0), rr_ptr);
    end
    $display("[TB] row reset: next pixel on lane 0");
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic test_back_pressure();
    do_reset();
    out_ready = 4'b0000;
    drive(1'b0, 2'd1, 8'h33, 1'b1, 1'b0);
    drive(1'b0, 2'd1, 8'h44, 1'b1, 1'b0);
    #1;
    tests++;
    if (in_ready !== 1'b0 || out_valid !== 4'b0010 || lane(1) !== 8'h33) begin
      fails++;
      $display("FAIL bp_stall: in_ready=%b valid=%b lane1=%h, want 0/0010/33", in_ready, out_valid, lane(1));
    end
    @(posedge clk); #1;
    tests++;
    if (out_valid !== 4'b0010 || lane(1) !== 8'h33) begin
      fails++;
      $display("FAIL bp_hold: valid=%b lane1=%h, want 0010/33", out_valid, lane(1));
    end
    @(negedge clk);
    out_ready = 4'b0010;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL bp_release_ready: in_ready=%b, want 1", in_ready);
    end
    @(posedge clk); #1;
    tests++;
    if (out_valid !== 4'b0010 || lane(1) !== 8'h44) begin
      fails++;
      $display("FAIL bp_load_drain: valid=%b lane1=%h, want 0010/44", out_valid, lane(1));
    end
    drive(1'b0, 2'd1, 8'h00, 1'b0, 1'b0);
    @(posedge clk); #1;
    tests++;
    if (out_valid !== 4'b0000 || lane(1) !== 8'h44) begin
      fails++;
      $display("FAIL bp_drain: valid=%b lane1=%h, want 0000/44", out_valid, lane(1));
    end
    $display("[TB] back-pressure: 33 held, 44 loaded on drain");
  endtask

  task automatic test_independent_lanes();
    do_reset();
    out_ready = 4'b1111;
    drive(1'b1, 2'd0, 8'h01, 1'b1, 1'b0);
    drive(1'b1, 2'd0, 8'h02, 1'b1, 1'b0);
    @(negedge clk);
    out_ready = 4'b0100;
    // addressed accept with in_last must leave rr_ptr alone
    mode = 1'b0; select = 2'd0; in_data = 8'h50; in_valid = 1'b1; in_last = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (rr_ptr !== 2'd2 || out_valid !== 4'b0011 || lane(0) !== 8'h50) begin
      fails++;
      $display("FAIL ind_setup: rr=%0d valid=%b lane0=%h, want 2/0011/50", rr_ptr, out_valid, lane(0));
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 2'd2, 8'h60 + 8'(i), 1'b1, 1'b0);
      #1;
      tests++;
      if (in_ready !== 1'b1) begin
        fails++;
        $display("FAIL ind_ready_%0d: in_ready=%b, want 1", i, in_ready);
      end
      @(posedge clk); #1;
      tests++;
      if (out_valid !== 4'b0111 || lane(2) !== 8'h60 + 8'(i) || lane(0) !== 8'h50 || lane(1) !== 8'h02) begin
        fails++;
        $display("FAIL ind_flow_%0d: valid=%b lane0=%h lane1=%h lane2=%h, want 0111/50/02/%h",
                 i, out_valid, lane(0), lane(1), lane(2), 8'h60 + 8'(i));
      end
      $display("[TB] lane 2 pixel %h, lane 0 stalled", 8'h60 + 8'(i));
    end
    tests++;
    if (rr_ptr !== 2'd2) begin
      fails++;
      $display("FAIL ind_rr_hold: rr=%0d, want 2", rr_ptr);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_out_of_range();
    do_reset();
    @(negedge clk);
    out_ready3 = 3'b111;
    mode3 = 1'b0; select3 = 2'd3; in_data3 = 8'h77; in_valid3 = 1'b1; in_last3 = 1'b0;
    #1;
    tests++;
    if (in_ready3 !== 1'b0) begin
      fails++;
      $display("FAIL oor_ready: in_ready=%b, want 0", in_ready3);
    end
    @(posedge clk); #1;
    tests++;
    if (out_valid3 !== 3'b000 || out_data3 !== 24'h0) begin
      fails++;
      $display("FAIL oor_noload: valid=%b data=%h, want 000/0", out_valid3, out_data3);
    end
    @(negedge clk);
    select3 = 2'd0;
    #1;
    tests++;
    if (in_ready3 !== 1'b1) begin
      fails++;
      $display("FAIL oor_switch_ready: in_ready=%b, want 1", in_ready3);
    end
    @(posedge clk); #1;
    tests++;
    if (out_valid3 !== 3'b001 || out_data3[7:0] !== 8'h77) begin
      fails++;
      $display("FAIL oor_switch_load: valid=%b lane0=%h, want 001/77", out_valid3, out_data3[7:0]);
    end
    // three round-robin pixels must wrap the pointer 2 -> 0 on a 3-lane build
    @(negedge clk);
    mode3 = 1'b1; in_data3 = 8'h80;
    repeat (2) @(negedge clk);
    #1;
    tests++;
    if (rr_ptr3 !== 2'd2) begin
      fails++;
      $display("FAIL oor_rr_two: rr=%0d, want 2", rr_ptr3);
    end
    @(posedge clk); #1;
    tests++;
    if (rr_ptr3 !== 2'd0) begin
      fails++;
      $display("FAIL oor_rr_wrap: rr=%0d, want 0", rr_ptr3);
    end
    $display("[TB] 3-lane: select 3 refused, pointer wraps at 2");
    @(negedge clk); in_valid3 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_row_reset();
    test_back_pressure();
    test_independent_lanes();
    test_out_of_range();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pixel_demux.md
Name: pixel_demux

Overview:
- Distributes a single registered pixel stream to NUM_OUT parallel output lanes. This is the inverse of the readout mux.
- Sits between the ADC/pixel serializer and per-column-group processing lanes.
- Lane choice comes from an explicit select input or from an internal round-robin pointer.
- Each lane has a one-entry output register with valid/ready handshake, so lanes back-pressure independently.

Parameters:
- NUM_OUT, default 4: number of output lanes, 2..16.
- BUS_WIDTH, default 8: pixel data width in bits.
- SEL_WIDTH, default 2: select/pointer width; must equal clog2(NUM_OUT).

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- mode  input  1  0 = addressed (use select); 1 = round-robin (use rr_ptr).
- select  input  SEL_WIDTH  target lane in addressed mode.
- in_data  input  BUS_WIDTH  input pixel.
- in_valid  input  1  in_data valid.
- in_last  input  1  last pixel of row; qualified by in_valid.
- in_ready  output  1  block accepts in_data this cycle.
- out_data  output  NUM_OUT*BUS_WIDTH  lane k occupies bits [k*BUS_WIDTH +: BUS_WIDTH].
- out_valid  output  NUM_OUT  per-lane valid.
- out_ready  input  NUM_OUT  per-lane downstream ready.
- rr_ptr  output  SEL_WIDTH  current round-robin pointer.

Behaviour:
- Reset (async, active-high): all out_valid=0, all out_data=0, rr_ptr=0. in_ready follows combinationally from these cleared values.
- Reset asserted mid-transfer: any pending lane data is discarded and nothing is replayed.
- Target lane: tgt = mode ? rr_ptr : select.
- Target range check: if tgt >= NUM_OUT, then in_ready=0 and nothing is accepted. This case is only reachable when NUM_OUT is not a power of 2.
- in_ready is combinational: in_ready = (tgt < NUM_OUT) && (!out_valid[tgt] || out_ready[tgt]). It depends only on select/mode/state/out_ready, never on in_valid.
- Accept: accept = in_valid && in_ready.
- Load: on accept, at the next clk edge out_data[tgt] <= in_data and out_valid[tgt] <= 1.
- Latency: exactly 1 cycle from accept to out_valid.
- Throughput: 1 pixel/cycle while the target lane drains every cycle.
- Per lane k, evaluated each edge:
  - load && drain: valid stays 1, data replaced with the new pixel.
  - load only: valid 1, new data.
  - drain only (out_valid[k] && out_ready[k]): valid goes 0, data held.
  - neither: hold.
- Stalled lane: out_data[k] must remain stable while out_valid[k] && !out_ready[k].
- Non-target lanes drain independently during the same cycle.
- Round-robin pointer:
  - Updates only on accept while mode=1.
  - Accept with in_last=1: rr_ptr <= 0, which takes priority over increment.
  - Otherwise rr_ptr <= (rr_ptr == NUM_OUT-1) ? 0 : rr_ptr+1.
  - With mode=0, rr_ptr holds its value.
- Accept in mode=0 with in_last=1: no pointer effect.
- Mode/select changes take effect combinationally in the same cycle. No internal state beyond the lane registers and rr_ptr.
- in_data is not modified. There is no arithmetic on pixel values.

Test Plan:
- Reset: assert reset mid-stream with lane 2 valid holding 0xA5 → out_valid=0000, out_data all 0, rr_ptr=0 immediately; after release, the first accept goes to lane 0.
- Round-robin: mode=1, all out_ready=1, send 0x10..0x17 over 8 consecutive cycles → lanes 0,1,2,3,0,1,2,3 receive 0x10,0x11,0x12,0x13,0x14,0x15,0x16,0x17 with 1-cycle latency each; rr_ptr wraps 3→0; in_ready held 1 throughout.
- Row reset: mode=1, send 3 pixels with in_last=1 on the 3rd → next pixel lands on lane 0 (not lane 3); rr_ptr=0.
- Back-pressure: mode=0, select=1, out_ready[1]=0, send 0x33 then 0x44 → 0x33 latched on lane 1, in_ready=0 on the next cycle; out_data lane 1 stays 0x33. Raise out_ready[1] → 0x44 accepted the same cycle and visible next cycle (simultaneous load and drain, valid stays 1).
- Independent lanes: lane 0 stalled with valid data, select=2, out_ready[2]=1 → traffic to lane 2 flows at 1/cycle; lane 0 data unchanged.
- Out-of-range (NUM_OUT=3, SEL_WIDTH=2): mode=0, select=3, in_valid=1 → in_ready=0, no lane loads. Then switch select=0 in the same cycle → accepted.
